// File: rtl/tdm_pkg.sv
// Shared TDM definitions for the mux-side framer and the demux receiver.
package tdm_pkg;

  localparam int unsigned TDM_NCH   = 8;
  localparam int unsigned TDM_WIDTH = 4;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

endpackage

// File: rtl/tdm_demux8_4bit_if.sv
// Slot-stream input and rebuilt-channel output bundle of the TDM demux.
interface tdm_demux8_4bit_if
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH = TDM_WIDTH,
  parameter int unsigned NCH   = TDM_NCH
);

  localparam int unsigned SW = $clog2(NCH);

  logic [WIDTH-1:0]     din;
  logic                 din_valid;
  logic                 frame_start;
  logic [NCH*WIDTH-1:0] y;
  logic                 frame_done;
  logic                 sync_err;
  logic [SW-1:0]        slot;

  modport master (
    output din, din_valid, frame_start,
    input  y, frame_done, sync_err, slot
  );

  modport slave (
    input  din, din_valid, frame_start,
    output y, frame_done, sync_err, slot
  );

endinterface

// File: rtl/tdm_slot_ctr.sv
// Slot index counter: clear has priority over load-1, which has priority over increment.
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter int unsigned NCH = TDM_NCH,
  localparam int unsigned SW = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load1_i,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [SW-1:0] slot_o,
  output logic          is_last_o
);

  logic [SW-1:0] slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (clr_i) begin
      slot_d = '0;
    end else if (load1_i) begin
      slot_d = SW'(1);
    end else if (inc_i) begin
      slot_d = slot_q + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o    = slot_q;
  assign is_last_o = (slot_q == SW'(NCH - 1));

endmodule

// File: rtl/tdm_demux8_4bit.sv
// TDM receiver: collects one word per slot into shadow registers and publishes
// the whole frame to y only when the last slot arrives.
module tdm_demux8_4bit
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH = TDM_WIDTH,
  parameter int unsigned NCH   = TDM_NCH
) (
  input logic               clk,
  input logic               rst,
  tdm_demux8_4bit_if.slave  bus
);

  localparam int unsigned SW = $clog2(NCH);

  logic [0:0]           state_q, state_d;
  logic [WIDTH-1:0]     shadow_q [NCH];
  logic [WIDTH-1:0]     shadow_d [NCH];
  logic [NCH*WIDTH-1:0] y_q, y_d;
  logic                 frame_done_q, frame_done_d;
  logic                 sync_err_q, sync_err_d;

  logic          ctr_load1, ctr_inc, ctr_clr, is_last;
  logic [SW-1:0] slot;

  tdm_slot_ctr #(
    .NCH (NCH)
  ) u_slot_ctr (
    .clk       (clk),
    .rst       (rst),
    .load1_i   (ctr_load1),
    .inc_i     (ctr_inc),
    .clr_i     (ctr_clr),
    .slot_o    (slot),
    .is_last_o (is_last)
  );

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    y_d          = y_q;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    ctr_load1    = 1'b0;
    ctr_inc      = 1'b0;
    ctr_clr      = 1'b0;

    if (bus.din_valid) begin
      if (bus.frame_start) begin
        // A start mid-frame abandons the partial frame and restarts at slot 0.
        sync_err_d  = (state_q == ST_COLLECT);
        shadow_d[0] = bus.din;
        ctr_load1   = 1'b1;
        state_d     = ST_COLLECT;
      end else if (state_q == ST_COLLECT) begin
        shadow_d[slot] = bus.din;
        if (is_last) begin
          // The last word bypasses the shadow so y updates on its own edge.
          for (int i = 0; i < NCH - 1; i++) begin
            y_d[i*WIDTH +: WIDTH] = shadow_q[i];
          end
          y_d[(NCH-1)*WIDTH +: WIDTH] = bus.din;
          frame_done_d = 1'b1;
          ctr_clr      = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          ctr_inc = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      y_q          <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      y_q          <= y_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign bus.y          = y_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sync_err   = sync_err_q;
  assign bus.slot       = slot;

endmodule

// File: tb/tb_tdm_demux8_4bit.sv
// Directed bench for tdm_demux8_4bit with a scoreboard of expected frames.
module tb_tdm_demux8_4bit;

  logic clk;
  logic rst;

  tdm_demux8_4bit_if bus ();

  tdm_demux8_4bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_done = 0;
  int n_sync = 0;
  int last_done_cyc = 0;
  int done_gap = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] seq(input int start, input int step);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(start + step * i);
    end
    return r;
  endfunction

  // One clock edge; outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    chk("pulse_exclusive", 32'(bus.frame_done & bus.sync_err), 32'd0);
    if (bus.frame_done) begin
      n_done++;
      done_gap      = cyc - last_done_cyc;
      last_done_cyc = cyc;
      if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else                   chk("frame_y", bus.y, exp_q.pop_front());
    end
    if (bus.sync_err) n_sync++;
  endtask

  task automatic send(input logic [3:0] d, input logic fs);
    @(negedge clk);
    bus.din         = d;
    bus.din_valid   = 1'b1;
    bus.frame_start = fs;
    tick();
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.din         = '0;
    bus.din_valid   = 1'b0;
    bus.frame_start = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_frame(input int start, input int step);
    for (int i = 0; i < 8; i++) begin
      send(4'(start + step * i), i == 0);
    end
  endtask

  initial begin
    int base_d;
    int base_s;
    logic [31:0] frame_a;

    // 1: reset
    rst             = 1'b1;
    bus.din         = '0;
    bus.din_valid   = 1'b0;
    bus.frame_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_y", bus.y, 32'd0);
    chk("rst_slot", 32'(bus.slot), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_y", bus.y, 32'd0);
    chk("post_rst_done", 32'(bus.frame_done), 32'd0);
    chk("post_rst_sync", 32'(bus.sync_err), 32'd0);
    chk("post_rst_slot", 32'(bus.slot), 32'd0);

    // 2: contiguous frame 1..8
    base_d = n_done;
    exp_q.push_back(seq(1, 1));
    for (int i = 0; i < 8; i++) begin
      send(4'(i + 1), i == 0);
      chk("t2_slot", 32'(bus.slot), 32'((i + 1) % 8));
      if (i < 7) chk("t2_no_early_done", 32'(n_done), 32'(base_d));
    end
    chk("t2_done_at_last", 32'(n_done), 32'(base_d + 1));
    idle(2);
    chk("t2_done_once", 32'(n_done), 32'(base_d + 1));
    chk("t2_y", bus.y, seq(1, 1));

    // 3: frame A, then gapped frame 1..8; y holds A until the last word
    frame_a = seq(15, -1);
    exp_q.push_back(frame_a);
    send_frame(15, -1);
    idle(1);
    chk("t3_y_a", bus.y, frame_a);
    base_d = n_done;
    exp_q.push_back(seq(1, 1));
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        idle($urandom_range(1, 3));
        chk("t3_slot_gap", 32'(bus.slot), 32'(i));
      end
      send(4'(i + 1), i == 0);
      if (i < 7) chk("t3_y_hold", bus.y, frame_a);
    end
    idle(2);
    chk("t3_done", 32'(n_done), 32'(base_d + 1));
    chk("t3_y", bus.y, seq(1, 1));

    // 4: resync after 4 words
    base_d = n_done;
    base_s = n_sync;
    exp_q.push_back(seq(9, 1));
    for (int i = 0; i < 4; i++) send(4'(i + 1), i == 0);
    chk("t4_no_sync_yet", 32'(n_sync), 32'(base_s));
    send(4'd9, 1'b1);
    chk("t4_sync", 32'(n_sync), 32'(base_s + 1));
    chk("t4_slot", 32'(bus.slot), 32'd1);
    chk("t4_y_hold", bus.y, seq(1, 1));
    for (int i = 0; i < 7; i++) send(4'(10 + i), 1'b0);
    idle(2);
    chk("t4_done", 32'(n_done), 32'(base_d + 1));
    chk("t4_sync_once", 32'(n_sync), 32'(base_s + 1));
    chk("t4_y", bus.y, seq(9, 1));

    // 5: back-to-back frames
    base_d = n_done;
    exp_q.push_back(seq(1, 1));
    exp_q.push_back(seq(8, -1));
    send_frame(1, 1);
    send_frame(8, -1);
    chk("t5_gap", 32'(done_gap), 32'd8);
    idle(2);
    chk("t5_done", 32'(n_done), 32'(base_d + 2));
    chk("t5_y", bus.y, seq(8, -1));

    // 6: asynchronous reset mid-frame
    for (int i = 0; i < 5; i++) send(4'(i + 1), i == 0);
    @(negedge clk);
    bus.din_valid   = 1'b0;
    bus.frame_start = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_y_async", bus.y, 32'd0);
    chk("t6_slot_async", 32'(bus.slot), 32'd0);
    #1;
    rst = 1'b0;
    idle(1);
    base_d = n_done;
    exp_q.push_back(seq(1, 1));
    send_frame(1, 1);
    idle(2);
    chk("t6_done", 32'(n_done), 32'(base_d + 1));
    chk("t6_y", bus.y, seq(1, 1));

    // 7: words without frame_start while idle are dropped
    base_d = n_done;
    base_s = n_sync;
    for (int i = 0; i < 5; i++) begin
      send(4'(i + 3), 1'b0);
      chk("t7_slot", 32'(bus.slot), 32'd0);
      chk("t7_y", bus.y, seq(1, 1));
    end
    idle(2);
    chk("t7_no_done", 32'(n_done), 32'(base_d));
    chk("t7_no_sync", 32'(n_sync), 32'(base_s));
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
